// File: rtl/addr_fifo_param.sv
// Show-ahead address FIFO between the layer address generator and the AXI read issuer.
// Optional ADDR_FIFO_ERR_EN adds sticky overflow/underflow flags (err_ovf, err_udf).
module addr_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int NUM_MODES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MODES-1:0]   mode_en,
    input  logic                   flush,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level,
`ifdef ADDR_FIFO_ERR_EN
    output logic                   err_ovf,
    output logic                   err_udf,
`endif
    output logic                   almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     level_q;
    logic              empty;
    logic              full;
    logic              mode_any;
    logic              push;
    logic              pop;
    logic              clr;

    // Status decode: wrap bit distinguishes full from empty when indices match.
    always_comb begin
        mode_any = |mode_en;
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
        wr_ready = mode_any && !full;
        rd_valid = !empty;
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
        clr      = !rst_n || flush;
    end

    // Show-ahead head; forced to zero while nothing is stored.
    always_comb begin
        rd_data = '0;
        if (!empty) begin
            rd_data = mem[rd_ptr[AW-1:0]];
        end
    end

    always_comb begin
        level       = level_q;
        almost_full = (level_q >= PW'(AFULL_TH));
    end

    // Storage write; contents are never cleared, only pointers are.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; flush and reset win over any handshake.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Registered occupancy tracks net push/pop each cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef ADDR_FIFO_ERR_EN
    // Sticky protocol-error flags; observation only, never gate the FIFO.
    always_ff @(posedge clk) begin
        if (clr) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_valid && mode_any && full) begin
                err_ovf <= 1'b1;
            end
            if (rd_ready && empty) begin
                err_udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addr_fifo_param.sv
// Directed table-driven bench for addr_fifo_param (DEPTH=4, AFULL_TH=3).
// Build with ADDR_FIFO_ERR_EN defined to also exercise the error flags.
module tb_addr_fifo_param;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mode_en;
    logic        flush;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [2:0]  level;
    logic        almost_full;
`ifdef ADDR_FIFO_ERR_EN
    logic        err_ovf;
    logic        err_udf;
`endif

    int n_total;
    int n_pass;

    addr_fifo_param #(
        .DATA_W   (32),
        .DEPTH    (4),
        .AFULL_TH (3),
        .NUM_MODES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_en    (mode_en),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .level      (level),
`ifdef ADDR_FIFO_ERR_EN
        .err_ovf    (err_ovf),
        .err_udf    (err_udf),
`endif
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  mode;
        logic        fl;
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic [2:0]  lvl;
        logic        rv;
        logic [31:0] rd;
        logic        wrdy;
        logic        af;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic rst, logic [3:0] mode, logic fl,
                                logic wv, logic [31:0] wd, logic rr,
                                logic [2:0] lvl, logic rv, logic [31:0] rd,
                                logic wrdy, logic af);
        vec_t v;
        v.rst  = rst;
        v.mode = mode;
        v.fl   = fl;
        v.wv   = wv;
        v.wd   = wd;
        v.rr   = rr;
        v.lvl  = lvl;
        v.rv   = rv;
        v.rd   = rd;
        v.wrdy = wrdy;
        v.af   = af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] mode,
                         input logic fl, input logic wv,
                         input logic [31:0] wd, input logic rr);
        rst_n    = rst;
        mode_en  = mode;
        flush    = fl;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        mode_en  = 4'b0001;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;

        // 1: reset, fill to full, drain in order
        vt.push_back(mk(0, 4'h1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0));
        vt.push_back(mk(1, 4'h1, 0, 1, 32'h100, 0, 1, 1, 32'h100, 1, 0));
        vt.push_back(mk(1, 4'h1, 0, 1, 32'h104, 0, 2, 1, 32'h100, 1, 0));
        vt.push_back(mk(1, 4'h1, 0, 1, 32'h108, 0, 3, 1, 32'h100, 1, 1));
        vt.push_back(mk(1, 4'h1, 0, 1, 32'h10C, 0, 4, 1, 32'h100, 0, 1));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 3, 1, 32'h104, 1, 1));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 2, 1, 32'h108, 1, 0));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 1, 1, 32'h10C, 1, 0));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   1, 0));
        // 2: full + offer + pop -> pop only, offered word dropped
        vt.push_back(mk(1, 4'h2, 0, 1, 32'h200, 0, 1, 1, 32'h200, 1, 0));
        vt.push_back(mk(1, 4'h2, 0, 1, 32'h204, 0, 2, 1, 32'h200, 1, 0));
        vt.push_back(mk(1, 4'h2, 0, 1, 32'h208, 0, 3, 1, 32'h200, 1, 1));
        vt.push_back(mk(1, 4'h2, 0, 1, 32'h20C, 0, 4, 1, 32'h200, 0, 1));
        vt.push_back(mk(1, 4'h2, 0, 1, 32'hDEAD, 1, 3, 1, 32'h204, 1, 1));
        vt.push_back(mk(1, 4'h2, 0, 0, 32'h0,   1, 2, 1, 32'h208, 1, 0));
        vt.push_back(mk(1, 4'h2, 0, 0, 32'h0,   1, 1, 1, 32'h20C, 1, 0));
        vt.push_back(mk(1, 4'h2, 0, 0, 32'h0,   1, 0, 0, 32'h0,   1, 0));
        // 3: push into empty with rd_ready -> void pop, no fall-through
        vt.push_back(mk(1, 4'h1, 0, 1, 32'hA0,  1, 1, 1, 32'hA0,  1, 0));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   1, 0));
        // 4: streaming at level 2 across pointer wraps
        vt.push_back(mk(1, 4'h1, 0, 1, 32'hF0,  0, 1, 1, 32'hF0,  1, 0));
        vt.push_back(mk(1, 4'h1, 0, 1, 32'hF1,  0, 2, 1, 32'hF0,  1, 0));
        for (int k = 0; k < 10; k++) begin
            vt.push_back(mk(1, 4'h1, 0, 1, 32'(k), 1, 2, 1,
                            (k == 0) ? 32'hF1 : 32'(k - 1), 1, 0));
        end
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 1, 1, 32'h9,   1, 0));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   1, 0));
        // 5: mode_en drop blocks writes, reads drain; then flush
        vt.push_back(mk(1, 4'h8, 0, 1, 32'h300, 0, 1, 1, 32'h300, 1, 0));
        vt.push_back(mk(1, 4'h8, 0, 1, 32'h304, 0, 2, 1, 32'h300, 1, 0));
        vt.push_back(mk(1, 4'h8, 0, 1, 32'h308, 0, 3, 1, 32'h300, 1, 1));
        vt.push_back(mk(1, 4'h0, 0, 1, 32'hBAD, 0, 3, 1, 32'h300, 0, 1));
        vt.push_back(mk(1, 4'h0, 0, 1, 32'hBAD, 1, 2, 1, 32'h304, 0, 0));
        vt.push_back(mk(1, 4'h0, 0, 1, 32'hBAD, 1, 1, 1, 32'h308, 0, 0));
        vt.push_back(mk(1, 4'h0, 0, 1, 32'hBAD, 1, 0, 0, 32'h0,   0, 0));
        vt.push_back(mk(1, 4'h4, 0, 1, 32'h400, 0, 1, 1, 32'h400, 1, 0));
        vt.push_back(mk(1, 4'h4, 0, 1, 32'h404, 0, 2, 1, 32'h400, 1, 0));
        vt.push_back(mk(1, 4'h4, 1, 1, 32'h408, 1, 0, 0, 32'h0,   1, 0));
        vt.push_back(mk(1, 4'h4, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0));
        // reset mid-operation
        vt.push_back(mk(1, 4'h1, 0, 1, 32'h500, 0, 1, 1, 32'h500, 1, 0));
        vt.push_back(mk(0, 4'h1, 0, 1, 32'h504, 0, 0, 0, 32'h0,   1, 0));
        vt.push_back(mk(1, 4'h1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 0));

        @(negedge clk);
        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].mode, vt[i].fl, vt[i].wv, vt[i].wd, vt[i].rr);
            chk($sformatf("v%0d.level", i),    32'(level),       32'(vt[i].lvl));
            chk($sformatf("v%0d.rd_valid", i), 32'(rd_valid),    32'(vt[i].rv));
            chk($sformatf("v%0d.rd_data", i),  rd_data,          vt[i].rd);
            chk($sformatf("v%0d.wr_ready", i), 32'(wr_ready),    32'(vt[i].wrdy));
            chk($sformatf("v%0d.afull", i),    32'(almost_full), 32'(vt[i].af));
        end

        // Held offers while full are all dropped; order intact afterwards
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'h1, 0, 1, 32'h600 + 32'(k), 0);
        end
        drive(1, 4'h1, 0, 1, 32'h6FF, 0);
        drive(1, 4'h1, 0, 1, 32'h6FE, 0);
        chk("hold.level", 32'(level), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold.rd%0d", k), rd_data, 32'h600 + 32'(k));
            drive(1, 4'h1, 0, 0, 32'h0, 1);
        end
        chk("hold.empty", 32'(rd_valid), 32'd0);

`ifdef ADDR_FIFO_ERR_EN
        drive(1, 4'h1, 1, 0, 32'h0, 0);
        chk("err.ovf_clr0", 32'(err_ovf), 32'd0);
        chk("err.udf_clr0", 32'(err_udf), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'h1, 0, 1, 32'h700 + 32'(k), 0);
        end
        chk("err.ovf_pre", 32'(err_ovf), 32'd0);
        drive(1, 4'h1, 0, 1, 32'h7FF, 0);
        chk("err.ovf_set", 32'(err_ovf), 32'd1);
        drive(1, 4'h1, 0, 0, 32'h0, 0);
        chk("err.ovf_held", 32'(err_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'h1, 0, 0, 32'h0, 1);
        end
        chk("err.udf_pre", 32'(err_udf), 32'd0);
        drive(1, 4'h1, 0, 0, 32'h0, 1);
        chk("err.udf_set", 32'(err_udf), 32'd1);
        chk("err.ovf_still", 32'(err_ovf), 32'd1);
        drive(1, 4'h1, 1, 0, 32'h0, 0);
        chk("err.ovf_flush", 32'(err_ovf), 32'd0);
        chk("err.udf_flush", 32'(err_udf), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
